// File: rtl/gestion_piles_pkg.sv
// Shared constants, FSM state type and height saturation helper for the stacking game.
// Also used by the gravity block so column numbering and height limits agree.
package gestion_piles_pkg;

  localparam logic [2:0] MAX_HAUTEUR     = 3'd7;
  localparam logic [1:0] COL_GAUCHE      = 2'd0;
  localparam logic [1:0] COL_CENTRE      = 2'd1;
  localparam logic [1:0] COL_DROITE      = 2'd2;
  localparam int         NB_CLIGNOTE_DEF = 3;

  typedef enum logic [1:0] {
    JEU    = 2'd0,
    EFFACE = 2'd1,
    FIGE   = 2'd2
  } etat_t;

  // Add and subtract in 4 bits first, so +1 and -1 together cancel cleanly at 0 and at 7.
  function automatic logic [2:0] sat_hauteur(input logic [2:0] h, input logic inc, input logic dec);
    logic [3:0] t;
    t = {1'b0, h} + {3'b000, inc} - {3'b000, dec};
    if (t == 4'hF)
      return 3'd0;
    else if (t > {1'b0, MAX_HAUTEUR})
      return MAX_HAUTEUR;
    else
      return t[2:0];
  endfunction

endpackage

// File: rtl/detecteur_front.sv
// Button synchroniser (2 flops) plus registered rising-edge detector.
// One press gives a single one-cycle event 3 clk edges after the input rises.
module detecteur_front (
  input  logic clk,
  input  logic rst_n,
  input  logic bouton,
  output logic front
);

  logic sync1, sync2, prec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prec  <= 1'b0;
      front <= 1'b0;
    end else begin
      sync1 <= bouton;
      sync2 <= sync1;
      prec  <= sync2;
      front <= sync2 & ~prec;
    end
  end

endmodule

// File: rtl/gestion_piles.sv
// Column heights, cursor, score and line-clear flash for a three-column stacking game.
// Outputs are registered; inputs are one-cycle events with no backpressure.
module gestion_piles
  import gestion_piles_pkg::*;
#(
  parameter int NB_CLIGNOTE = NB_CLIGNOTE_DEF,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pulse,
  input  logic               PlusGauche,
  input  logic               PlusCentre,
  input  logic               PlusDroite,
  input  logic               Aligne,
  input  logic               Perdu,
  input  logic               boutonGauche,
  input  logic               boutonDroite,
  output logic [2:0]         hauteurGauche,
  output logic [2:0]         hauteurCentre,
  output logic [2:0]         hauteurDroite,
  output logic [1:0]         col,
  output logic [SCORE_W-1:0] score,
  output logic               clignote
);

  localparam int             CPT_W   = (NB_CLIGNOTE > 1) ? $clog2(NB_CLIGNOTE) : 1;
  localparam logic [CPT_W-1:0] CPT_DER = CPT_W'(NB_CLIGNOTE - 1);

  logic             rst_meta, rst_n;
  etat_t            etat, etat_suiv;
  logic [CPT_W-1:0] cpt;
  logic             fin_efface, actif;
  logic             ev_gauche, ev_droite;

  // Reset asserts immediately, releases two edges later in the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  detecteur_front u_front_gauche (
    .clk    (clk),
    .rst_n  (rst_n),
    .bouton (boutonGauche),
    .front  (ev_gauche)
  );

  detecteur_front u_front_droite (
    .clk    (clk),
    .rst_n  (rst_n),
    .bouton (boutonDroite),
    .front  (ev_droite)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      etat <= JEU;
    else
      etat <= etat_suiv;
  end

  always_comb begin
    etat_suiv  = etat;
    fin_efface = 1'b0;
    case (etat)
      JEU: begin
        if (Perdu)
          etat_suiv = FIGE;
        else if (Aligne)
          etat_suiv = EFFACE;
      end
      EFFACE: begin
        if (Perdu)
          etat_suiv = FIGE;
        else if (pulse && cpt == CPT_DER) begin
          etat_suiv  = JEU;
          fin_efface = 1'b1;
        end
      end
      FIGE:    etat_suiv = FIGE;
      default: etat_suiv = JEU;
    endcase
  end

  assign actif = (etat != FIGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hauteurGauche <= 3'd0;
      hauteurCentre <= 3'd0;
      hauteurDroite <= 3'd0;
      col           <= COL_CENTRE;
      score         <= '0;
      clignote      <= 1'b0;
      cpt           <= '0;
    end else begin
      hauteurGauche <= sat_hauteur(hauteurGauche, PlusGauche & actif, fin_efface);
      hauteurCentre <= sat_hauteur(hauteurCentre, PlusCentre & actif, fin_efface);
      hauteurDroite <= sat_hauteur(hauteurDroite, PlusDroite & actif, fin_efface);

      if (fin_efface && score != '1)
        score <= score + SCORE_W'(1);

      // Counter starts from 0 on entry and only advances on game ticks while flashing.
      if (etat_suiv == EFFACE)
        cpt <= (etat == EFFACE) ? cpt + CPT_W'(pulse) : '0;
      else
        cpt <= '0;
      clignote <= (etat_suiv == EFFACE);

      if (actif) begin
        if (ev_gauche && !ev_droite && col != COL_GAUCHE)
          col <= col - 2'd1;
        else if (ev_droite && !ev_gauche && col != COL_DROITE)
          col <= col + 2'd1;
      end
    end
  end

endmodule

// File: doc/gestion_piles.md
GESTION_PILES -- requirements
Module: gestion_piles

Interface
REQ-001 Parameter NB_CLIGNOTE, default 3: pulse count spent in the line-clear flash.
REQ-002 Parameter SCORE_W, default 8: score width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 pulse  in  1  one-cycle game tick, shared with the gravity block.
REQ-006 PlusGauche / PlusCentre / PlusDroite  in  1 each  one-cycle "brick landed" on column 0/1/2.
REQ-007 Aligne  in  1  one-cycle "bottom row complete" request.
REQ-008 Perdu  in  1  level "game lost" from the gravity block.
REQ-009 boutonGauche / boutonDroite  in  1 each  raw asynchronous push-buttons.
REQ-010 hauteurGauche / hauteurCentre / hauteurDroite  out  3 each  registered column heights, 0..7.
REQ-011 col  out  2  registered selected column, 0 = left, 1 = centre, 2 = right; 3 never driven.
REQ-012 score  out  SCORE_W  registered count of cleared rows.
REQ-013 clignote  out  1  registered; high while the flash runs.

Function
REQ-014 FSM states JEU, EFFACE, FIGE; the encoding is registered.
REQ-015 JEU -> EFFACE when Aligne=1 and Perdu=0.
- The flash counter loads 0 and clignote rises on the next edge.
REQ-016 EFFACE: each pulse increments the flash counter.
- On the pulse where the counter reaches NB_CLIGNOTE-1: all three heights decrement by 1 (floor at 0), score increments (saturates at all-ones), clignote drops, FSM returns to JEU.
REQ-017 In EFFACE, Aligne is ignored; no queuing.
REQ-018 Any state except FIGE: Perdu=1 -> FIGE on the next edge; clignote clears.
REQ-019 FIGE is absorbing until reset.
- Heights, col and score hold.
- All Plus*, Aligne and button inputs are ignored.
REQ-020 Plus* apply in JEU and EFFACE: the corresponding height +1, saturating at 7.
- Several Plus* in one cycle each apply independently.
REQ-021 Plus* and the EFFACE-final decrement in the same cycle: net change is 0 for that column; no saturation artefact at 0 or 7.
REQ-022 Plus* and Aligne in the same JEU cycle: the increment applies and EFFACE is entered.
REQ-023 Each button passes a 2-flop synchroniser, then rising-edge detection.
- One press gives exactly one one-cycle event, 3 cycles after the input rises.
REQ-024 Left event: col-1, floor 0.
- Right event: col+1, ceiling 2.
- Both in the same cycle: no change.
- col is updated in JEU and EFFACE only.
REQ-025 Height arithmetic is 4-bit internally before saturation; outputs never wrap.

Reset
REQ-026 Asynchronous assertion; synchronous deassertion through the clk domain (2-flop reset synchroniser).
REQ-027 Reset values:
- heights 0, col 1, score 0, clignote 0, FSM JEU, flash counter 0.
- Synchroniser flops 0, so no spurious button event after release.
REQ-028 Reset mid-EFFACE aborts the clear: no decrement, no score change.

Structure
REQ-029 A shared package holds:
- constants MAX_HAUTEUR=7, COL_GAUCHE=0, COL_CENTRE=1, COL_DROITE=2;
- the FSM state typedef;
- NB_CLIGNOTE default.
The gravity block uses the same constants.
REQ-030 One sub-module, detecteur_front: synchroniser plus rising-edge detector, instantiated once per button.

Verification
REQ-031 Reset, then PlusCentre x3 -> hauteurCentre=3, others 0, col=1, score=0.
REQ-032 Heights 2/1/4, Aligne, then 3 pulses:
- clignote=1 for exactly that span;
- then heights 1/0/3 and score=1.
REQ-033 hauteurGauche=7, PlusGauche -> stays 7.
- hauteurDroite=0 with a PlusDroite on the final EFFACE pulse -> stays 0.
REQ-034 col=0 with a left press -> col stays 0.
- Right press x3 -> col 1, 2, 2.
- Both buttons pressed on the same edge -> unchanged.
REQ-035 Perdu=1 mid-EFFACE -> FIGE; clignote=0; later PlusCentre, Aligne and buttons change nothing until reset_n=0.
REQ-036 reset_n low for 1 ns, asynchronous to clk, during EFFACE -> outputs go to their reset values immediately; score stays 0.
